machine_timer: RTL and testbench

MACHINE_TIMER -- requirements
Module: machine_timer

---
 rtl/machine_timer.sv | 144 ++++++++++++++
 tb/tb_machine_timer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/machine_timer.sv
// RISC-V style machine timer: 64-bit mtime/mtimecmp, MSIP, and a one-cycle-latency
// register bus with a two-state request/response handshake.
module machine_timer #(
    parameter int unsigned TICK_DIVIDE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bus_valid,
    input  logic        bus_write,
    input  logic [15:0] bus_address,
    input  logic [31:0] bus_write_data,
    output logic        bus_ready,
    output logic [31:0] bus_read_data,
    output logic        timer_interrupt_request,
    output logic        software_interrupt_request
);

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned TIME_W     = 64;
    localparam int unsigned PRESCALE_W = 16;

    localparam logic [ADDR_W-1:0] ADDR_MSIP        = 16'h0000;
    localparam logic [ADDR_W-1:0] ADDR_MTIMECMP_LO = 16'h4000;
    localparam logic [ADDR_W-1:0] ADDR_MTIMECMP_HI = 16'h4004;
    localparam logic [ADDR_W-1:0] ADDR_MTIME_LO    = 16'hBFF8;
    localparam logic [ADDR_W-1:0] ADDR_MTIME_HI    = 16'hBFFC;

    localparam logic [PRESCALE_W-1:0] TICK_LAST = PRESCALE_W'(TICK_DIVIDE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t                  state;
    logic [TIME_W-1:0]       mtime;
    logic [TIME_W-1:0]       mtimecmp;
    logic [PRESCALE_W-1:0]   prescale;
    logic [DATA_W-1:0]       shadow;
    logic                    msip;

    logic                    accept;
    logic                    wr;
    logic                    rd;
    logic                    mtime_wr;
    logic [ADDR_W-1:0]       word_addr;
    logic [DATA_W-1:0]       read_value;

    // Byte-lane bits are don't-care: every register is a full 32-bit word.
    assign word_addr = bus_address & 16'hFFFC;
    assign accept    = (state == IDLE) && bus_valid;
    assign wr        = accept && bus_write;
    assign rd        = accept && !bus_write;
    assign mtime_wr  = wr && ((word_addr == ADDR_MTIME_LO) || (word_addr == ADDR_MTIME_HI));

    assign software_interrupt_request = msip;

    // Read mux samples registers before any same-edge update.
    always_comb begin
        read_value = '0;
        case (word_addr)
            ADDR_MSIP:        read_value = {31'b0, msip};
            ADDR_MTIMECMP_LO: read_value = mtimecmp[31:0];
            ADDR_MTIMECMP_HI: read_value = mtimecmp[63:32];
            ADDR_MTIME_LO:    read_value = mtime[31:0];
            ADDR_MTIME_HI:    read_value = shadow;
            default:          read_value = '0;
        endcase
    end

    // Handshake FSM: accept in IDLE, pulse bus_ready for the single RESP cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus_ready     <= 1'b0;
            bus_read_data <= '0;
        end else begin
            bus_ready     <= 1'b0;
            bus_read_data <= '0;
            if (state == IDLE) begin
                if (bus_valid) begin
                    state     <= RESP;
                    bus_ready <= 1'b1;
                    if (!bus_write) begin
                        bus_read_data <= read_value;
                    end
                end
            end else begin
                state <= IDLE;
            end
        end
    end

    // Software-visible control registers and the MTIME_HI read shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msip     <= 1'b0;
            mtimecmp <= '1;
            shadow   <= '0;
        end else begin
            if (wr) begin
                case (word_addr)
                    ADDR_MSIP:        msip            <= bus_write_data[0];
                    ADDR_MTIMECMP_LO: mtimecmp[31:0]  <= bus_write_data;
                    ADDR_MTIMECMP_HI: mtimecmp[63:32] <= bus_write_data;
                    default:          ;
                endcase
            end
            if (rd && (word_addr == ADDR_MTIME_LO)) begin
                shadow <= mtime[63:32];
            end
        end
    end

    // Prescaled time base; a software write to mtime restarts the prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime    <= '0;
            prescale <= '0;
        end else if (mtime_wr) begin
            prescale <= '0;
            if (word_addr == ADDR_MTIME_LO) begin
                mtime[31:0] <= bus_write_data;
            end else begin
                mtime[63:32] <= bus_write_data;
            end
        end else if (prescale == TICK_LAST) begin
            prescale <= '0;
            mtime    <= mtime + 64'd1;
        end else begin
            prescale <= prescale + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_interrupt_request <= 1'b0;
        end else begin
            timer_interrupt_request <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: tb/tb_machine_timer.sv
// Scoreboard bench for machine_timer: one DUT at TICK_DIVIDE=1, one at TICK_DIVIDE=4.
module tb_machine_timer;

    typedef struct {
        logic        chk;
        logic [31:0] exp;
        logic [127:0] name;
    } sb_t;

    logic        clk;
    logic        rst_n;
    logic        bus_valid      [2];
    logic        bus_write      [2];
    logic [15:0] bus_address    [2];
    logic [31:0] bus_write_data [2];
    logic        bus_ready      [2];
    logic [31:0] bus_read_data  [2];
    logic        tirq           [2];
    logic        sirq           [2];

    sb_t q0[$];
    sb_t q1[$];
    sb_t e0;
    sb_t e1;
    int  tests  = 0;
    int  failed = 0;

    machine_timer #(.TICK_DIVIDE(1)) u_div1 (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .bus_valid                  (bus_valid[0]),
        .bus_write                  (bus_write[0]),
        .bus_address                (bus_address[0]),
        .bus_write_data             (bus_write_data[0]),
        .bus_ready                  (bus_ready[0]),
        .bus_read_data              (bus_read_data[0]),
        .timer_interrupt_request    (tirq[0]),
        .software_interrupt_request (sirq[0])
    );

    machine_timer #(.TICK_DIVIDE(4)) u_div4 (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .bus_valid                  (bus_valid[1]),
        .bus_write                  (bus_write[1]),
        .bus_address                (bus_address[1]),
        .bus_write_data             (bus_write_data[1]),
        .bus_ready                  (bus_ready[1]),
        .bus_read_data              (bus_read_data[1]),
        .timer_interrupt_request    (tirq[1]),
        .software_interrupt_request (sirq[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every bus_ready pulse pops one expected response.
    always @(negedge clk) begin
        if (rst_n && bus_ready[0]) begin
            tests++;
            if (q0.size() == 0) begin
                failed++;
                $display("FAIL stray_ready_div1: bus_ready=1 with no request outstanding");
            end else begin
                e0 = q0.pop_front();
                if (e0.chk && (bus_read_data[0] !== e0.exp)) begin
                    failed++;
                    $display("FAIL %0s: read_data=%h expected %h", e0.name, bus_read_data[0], e0.exp);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && bus_ready[1]) begin
            tests++;
            if (q1.size() == 0) begin
                failed++;
                $display("FAIL stray_ready_div4: bus_ready=1 with no request outstanding");
            end else begin
                e1 = q1.pop_front();
                if (e1.chk && (bus_read_data[1] !== e1.exp)) begin
                    failed++;
                    $display("FAIL %0s: read_data=%h expected %h", e1.name, bus_read_data[1], e1.exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Issue one request at a negedge; returns one idle cycle after the response.
    task automatic bus_xfer(input int sel, input logic wr, input logic [15:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp,
                            input logic [127:0] name);
        sb_t e;
        int  lat;
        e.chk  = !wr;
        e.exp  = exp;
        e.name = name;
        if (sel == 0) q0.push_back(e);
        else          q1.push_back(e);
        bus_valid[sel]      = 1'b1;
        bus_write[sel]      = wr;
        bus_address[sel]    = addr;
        bus_write_data[sel] = wdata;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus_ready[sel] && lat < 4);
        bus_valid[sel] = 1'b0;
        tests++;
        if (!bus_ready[sel]) begin
            failed++;
            $display("FAIL %0s_timeout: bus_ready=0 after %0d cycles, required within 1", name, lat);
            if (sel == 0) void'(q0.pop_back());
            else          void'(q1.pop_back());
        end else if (lat != 1) begin
            failed++;
            $display("FAIL %0s_latency: %0d cycles, required 1", name, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus_valid[i] = 1'b0;
            bus_write[i] = 1'b0;
            bus_address[i] = '0;
            bus_write_data[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            tests++;
            if ({bus_ready[i], bus_read_data[i], tirq[i], sirq[i]} !== 35'd0) begin
                failed++;
                $display("FAIL reset_outputs%0d: ready=%b rdata=%h tirq=%b sirq=%b, required all 0",
                         i, bus_ready[i], bus_read_data[i], tirq[i], sirq[i]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_tick_divide();
        repeat (40) @(posedge clk);
        @(negedge clk);
        bus_xfer(1, 1'b0, 16'hBFF8, 32'h0, 32'd10, "div4_mtime_lo");
        bus_xfer(1, 1'b0, 16'hBFFC, 32'h0, 32'd0, "div4_mtime_hi");
        bus_xfer(1, 1'b1, 16'hBFF8, 32'd100, 32'h0, "div4_wr_lo");
        bus_xfer(1, 1'b0, 16'hBFF8, 32'h0, 32'd100, "div4_prescale_a");
        bus_xfer(1, 1'b0, 16'hBFF8, 32'h0, 32'd100, "div4_prescale_b");
        bus_xfer(1, 1'b0, 16'hBFF8, 32'h0, 32'd101, "div4_prescale_c");
    endtask

    task automatic test_wrap();
        bus_xfer(0, 1'b1, 16'hBFFC, 32'hFFFF_FFFF, 32'h0, "wrap_wr_hi");
        bus_xfer(0, 1'b1, 16'hBFF8, 32'hFFFF_FFFF, 32'h0, "wrap_wr_lo");
        bus_xfer(0, 1'b0, 16'hBFF8, 32'h0, 32'h0, "wrap_rd_lo");
        bus_xfer(0, 1'b0, 16'hBFFC, 32'h0, 32'h0, "wrap_rd_hi");
    endtask

    task automatic test_shadow();
        bus_xfer(0, 1'b1, 16'hBFFC, 32'h1, 32'h0, "shadow_wr_hi");
        bus_xfer(0, 1'b1, 16'hBFF8, 32'hFFFF_FFFE, 32'h0, "shadow_wr_lo");
        bus_xfer(0, 1'b0, 16'hBFF8, 32'h0, 32'hFFFF_FFFF, "shadow_lo_carry");
        bus_xfer(0, 1'b0, 16'hBFFC, 32'h0, 32'h1, "shadow_hi_carry");
        bus_xfer(0, 1'b0, 16'hBFFA, 32'h0, 32'h3, "shadow_lo_again");
        bus_xfer(0, 1'b0, 16'hBFFC, 32'h0, 32'h2, "shadow_hi_again");
    endtask

    task automatic test_timer_irq();
        int m;
        bus_xfer(0, 1'b1, 16'h4000, 32'd100, 32'h0, "cmp_wr_lo");
        bus_xfer(0, 1'b1, 16'h4004, 32'h0, 32'h0, "cmp_wr_hi");
        bus_xfer(0, 1'b1, 16'hBFFC, 32'h0, 32'h0, "irq_mtime_hi");
        bus_xfer(0, 1'b1, 16'hBFF8, 32'h0, 32'h0, "irq_mtime_lo");
        m = 1;
        tests++;
        if (tirq[0] !== 1'b0) begin
            failed++;
            $display("FAIL irq_low_start: tirq=%b required 0", tirq[0]);
        end
        for (int i = 0; i < 200 && tirq[0] !== 1'b1; i++) begin
            @(negedge clk);
            m++;
        end
        tests++;
        if (tirq[0] !== 1'b1 || m != 101) begin
            failed++;
            $display("FAIL irq_rise: tirq=%b at mtime=%0d, required 1 first at mtime=101", tirq[0], m);
        end
        bus_valid[0] = 1'b1; bus_write[0] = 1'b1;
        bus_address[0] = 16'h4004; bus_write_data[0] = 32'h1;
        q0.push_back('{chk: 1'b0, exp: 32'h0, name: "irq_cmp_hi"});
        @(negedge clk);
        bus_valid[0] = 1'b0;
        tests++;
        if (bus_ready[0] !== 1'b1 || tirq[0] !== 1'b1) begin
            failed++;
            $display("FAIL irq_hold: ready=%b tirq=%b, required 1 1", bus_ready[0], tirq[0]);
        end
        @(negedge clk);
        tests++;
        if (tirq[0] !== 1'b0) begin
            failed++;
            $display("FAIL irq_fall: tirq=%b required 0", tirq[0]);
        end
    endtask

    task automatic test_msip();
        bus_xfer(0, 1'b1, 16'h0000, 32'hFFFF_FFFF, 32'h0, "msip_wr");
        tests++;
        if (sirq[0] !== 1'b1) begin
            failed++;
            $display("FAIL msip_sirq_set: sirq=%b required 1", sirq[0]);
        end
        bus_xfer(0, 1'b0, 16'h0000, 32'h0, 32'h1, "msip_rd");
        bus_xfer(0, 1'b0, 16'h0003, 32'h0, 32'h1, "msip_rd_byteoff");
        bus_xfer(0, 1'b1, 16'h8000, 32'hDEAD_BEEF, 32'h0, "unmapped_wr");
        bus_xfer(0, 1'b0, 16'h8000, 32'h0, 32'h0, "unmapped_rd");
        bus_xfer(0, 1'b0, 16'h4004, 32'h0, 32'h1, "cmp_hi_intact");
        bus_xfer(0, 1'b0, 16'h4000, 32'h0, 32'd100, "cmp_lo_intact");
        bus_xfer(0, 1'b1, 16'h0000, 32'h0, 32'h0, "msip_clr");
        tests++;
        if (sirq[0] !== 1'b0) begin
            failed++;
            $display("FAIL msip_sirq_clr: sirq=%b required 0", sirq[0]);
        end
    endtask

    task automatic test_back_to_back();
        bus_valid[0] = 1'b1; bus_write[0] = 1'b0; bus_address[0] = 16'h4000;
        q0.push_back('{chk: 1'b1, exp: 32'd100, name: "b2b_first"});
        @(negedge clk);
        tests++;
        if (bus_ready[0] !== 1'b1) begin
            failed++;
            $display("FAIL b2b_first_ready: ready=%b required 1", bus_ready[0]);
        end
        bus_address[0] = 16'h4004;
        q0.push_back('{chk: 1'b1, exp: 32'h1, name: "b2b_second"});
        @(negedge clk);
        tests++;
        if (bus_ready[0] !== 1'b0) begin
            failed++;
            $display("FAIL b2b_gap: ready=%b required 0", bus_ready[0]);
        end
        @(negedge clk);
        bus_valid[0] = 1'b0;
        tests++;
        if (bus_ready[0] !== 1'b1) begin
            failed++;
            $display("FAIL b2b_second_ready: ready=%b required 1", bus_ready[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_resp();
        bus_xfer(0, 1'b1, 16'h4004, 32'h0, 32'h0, "pre_cmp_hi");
        bus_xfer(0, 1'b1, 16'h0000, 32'h1, 32'h0, "pre_msip");
        tests++;
        if (tirq[0] !== 1'b1 || sirq[0] !== 1'b1) begin
            failed++;
            $display("FAIL pre_reset_irqs: tirq=%b sirq=%b, required 1 1", tirq[0], sirq[0]);
        end
        bus_valid[0] = 1'b1; bus_write[0] = 1'b0; bus_address[0] = 16'h4000;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        bus_valid[0] = 1'b0;
        #1;
        tests++;
        if ({bus_ready[0], bus_read_data[0], tirq[0], sirq[0]} !== 35'd0) begin
            failed++;
            $display("FAIL mid_resp_reset: ready=%b rdata=%h tirq=%b sirq=%b, required all 0",
                     bus_ready[0], bus_read_data[0], tirq[0], sirq[0]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (bus_ready[0] !== 1'b0) begin
                failed++;
                $display("FAIL post_reset_no_ready: ready=%b cycle %0d, required 0", bus_ready[0], i);
            end
        end
        bus_xfer(0, 1'b0, 16'h4000, 32'h0, 32'hFFFF_FFFF, "rst_cmp_lo");
        bus_xfer(0, 1'b0, 16'h4004, 32'h0, 32'hFFFF_FFFF, "rst_cmp_hi");
        bus_xfer(0, 1'b0, 16'h0000, 32'h0, 32'h0, "rst_msip");
        bus_xfer(0, 1'b0, 16'hBFF8, 32'h0, 32'd11, "rst_mtime_lo");
        tests++;
        if (tirq[0] !== 1'b0 || sirq[0] !== 1'b0) begin
            failed++;
            $display("FAIL post_reset_irqs: tirq=%b sirq=%b, required 0 0", tirq[0], sirq[0]);
        end
    endtask

    initial begin
        test_reset();
        test_tick_divide();
        test_wrap();
        test_shadow();
        test_timer_irq();
        test_msip();
        test_back_to_back();
        test_reset_mid_resp();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
